// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-order issue scoreboard with per-register write-back countdowns, shared write-port schedule and saturating stall counter.
// Define SCOREBOARD_FWD_EN to let RAW consumers issue one cycle earlier using the forwarded write-back result.
module reg_scoreboard #(
  parameter int NREGS   = 32,
  parameter int LAT_ALU = 3,
  parameter int LAT_MEM = 5,
  parameter int CNT_W   = 3,
  parameter int PERF_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic               issue_wr,
  input  logic               issue_vec,
  input  logic               issue_load,
  input  logic               use_rs1,
  input  logic               use_rs2,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic               rs1_vec,
  input  logic               rs2_vec,
  input  logic               flush,
  output logic               stall,
  output logic               issue_accept,
  output logic [NREGS-1:0]   busy_s,
  output logic [NREGS-1:0]   busy_v,
  output logic [LAT_MEM-1:0] wb_slot,
  output logic [PERF_W-1:0]  stall_cnt
);
  // A countdown of 1 is the write-back cycle itself; the register file writes through, so it is readable.
`ifdef SCOREBOARD_FWD_EN
  localparam logic [CNT_W-1:0] RDY = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] RDY = CNT_W'(1);
`endif
  localparam int LA = LAT_ALU - 1;
  localparam int LM = LAT_MEM - 1;
  logic [CNT_W-1:0]   cnt_s_q [NREGS];
  logic [CNT_W-1:0]   cnt_s_d [NREGS];
  logic [CNT_W-1:0]   cnt_v_q [NREGS];
  logic [CNT_W-1:0]   cnt_v_d [NREGS];
  logic [LAT_MEM-1:0] wb_slot_q, wb_slot_d;
  logic [PERF_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]   lat;
  logic               live, raw1, raw2, waw, port_hz, wr_go;
  assign lat  = issue_load ? CNT_W'(LAT_MEM) : CNT_W'(LAT_ALU);
  assign live = issue_valid && !flush && !rst;
  assign raw1 = use_rs1 && ((rs1_vec ? cnt_v_q[rs1] : cnt_s_q[rs1]) > RDY);
  assign raw2 = use_rs2 && ((rs2_vec ? cnt_v_q[rs2] : cnt_s_q[rs2]) > RDY);
  assign waw  = issue_wr && ((issue_vec ? cnt_v_q[issue_rd] : cnt_s_q[issue_rd]) != '0);
  // Bit k marks a write landing k cycles from now; a load lands beyond every existing reservation.
  assign port_hz      = issue_wr && !issue_load && wb_slot_q[LAT_ALU];
  assign stall        = live && (raw1 || raw2 || waw || port_hz);
  assign issue_accept = live && !stall;
  assign wr_go        = issue_accept && issue_wr;
  assign wb_slot      = wb_slot_q;
  assign stall_cnt    = stall_cnt_q;
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      busy_s[i]  = cnt_s_q[i] != '0;
      busy_v[i]  = cnt_v_q[i] != '0;
      cnt_s_d[i] = cnt_s_q[i] - CNT_W'(busy_s[i]);
      cnt_v_d[i] = cnt_v_q[i] - CNT_W'(busy_v[i]);
    end
    if (wr_go && !issue_vec && issue_rd != '0) cnt_s_d[issue_rd] = lat;
    if (wr_go && issue_vec) cnt_v_d[issue_rd] = lat;
    wb_slot_d = wb_slot_q >> 1;
    if (wr_go && issue_load) wb_slot_d[LM] = 1'b1;
    if (wr_go && !issue_load) wb_slot_d[LA] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_s_q     <= '{default: '0};
      cnt_v_q     <= '{default: '0};
      wb_slot_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_s_q   <= cnt_s_d;
      cnt_v_q   <= cnt_v_d;
      wb_slot_q <= wb_slot_d;
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end
endmodule
